// File: rtl/psum_col_fifo_pkg.sv
// Shared constants for the PE-array column output buffer.
package psum_col_fifo_pkg;

   localparam int unsigned COL     = 8;
   localparam int unsigned PSUM_BW = 16;
   localparam int unsigned DEPTH   = 16;

   // One extra pointer bit separates full from empty when the low bits match.
   function automatic int unsigned ptr_width(input int unsigned d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/psum_col_fifo_col_fifo.sv
// Single-column synchronous FIFO. Writes to a full FIFO are dropped.
// Reads from an empty FIFO are ignored.
module psum_col_fifo_col_fifo
   import psum_col_fifo_pkg::*;
#(
   parameter int unsigned depth = DEPTH,
   parameter int unsigned bw    = PSUM_BW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr,
   input  logic          rd,
   input  logic [bw-1:0] din,
   output logic [bw-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int unsigned PW = ptr_width(depth);
   localparam int unsigned AW = PW - 1;
   localparam logic [PW-1:0] PtrOne = PW'(1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [bw-1:0] mem_q [depth];
   logic [bw-1:0] mem_d [depth];

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d                = wr_ptr_q + PtrOne;
      end
      if (rd && !empty) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/psum_col_fifo.sv
// Column-aligned psum buffer: each column fills independently, and the SFU pops
// one full row at a time once every column holds data.
module psum_col_fifo
   import psum_col_fifo_pkg::*;
#(
   parameter int unsigned col     = COL,
   parameter int unsigned psum_bw = PSUM_BW,
   parameter int unsigned depth   = DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [col*psum_bw-1:0] in,
   input  logic                   rd,
   output logic [col*psum_bw-1:0] out,
   output logic                   out_vld,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   err_ovf,
   output logic                   err_udf
);

   logic [col-1:0]         col_full;
   logic [col-1:0]         col_empty;
   logic [col*psum_bw-1:0] head;
   logic                   rd_acc;

   logic [col*psum_bw-1:0] out_q, out_d;
   logic                   out_vld_q, out_vld_d;
   logic                   err_ovf_q, err_ovf_d;
   logic                   err_udf_q, err_udf_d;

   for (genvar k = 0; k < col; k++) begin : g_col
      psum_col_fifo_col_fifo #(
         .depth (depth),
         .bw    (psum_bw)
      ) u_col_fifo (
         .clk   (clk),
         .reset (reset),
         .wr    (wr[k]),
         .rd    (rd_acc),
         .din   (in[k*psum_bw +: psum_bw]),
         .dout  (head[k*psum_bw +: psum_bw]),
         .full  (col_full[k]),
         .empty (col_empty[k])
      );
   end

   // Flags depend only on registered pointers, never on this cycle's inputs.
   assign o_valid = ~|col_empty;
   assign o_full  = |col_full;
   assign o_ready = ~o_full;
   assign rd_acc  = rd && o_valid;

   always_comb begin
      out_d     = out_q;
      out_vld_d = 1'b0;
      err_ovf_d = err_ovf_q | (|(wr & col_full));
      err_udf_d = err_udf_q | (rd & ~o_valid);
      if (rd_acc) begin
         out_d     = head;
         out_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign out     = out_q;
   assign out_vld = out_vld_q;
   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;

endmodule

// File: tb/tb_psum_col_fifo.sv
// Self-checking bench for psum_col_fifo: per-column reference queues feed an
// expected-row scoreboard that is compared whenever out_vld should pulse.
module tb_psum_col_fifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 16;
   localparam int W     = COL * BW;

   logic           clk   = 1'b0;
   logic           reset = 1'b1;
   logic [COL-1:0] wr    = '0;
   logic [W-1:0]   din   = '0;
   logic           rd    = 1'b0;
   logic [W-1:0]   dout;
   logic           out_vld, o_valid, o_full, o_ready, err_ovf, err_udf;

   int n_checks = 0;
   int n_errors = 0;

   logic [BW-1:0] mdata [COL][DEPTH];
   int            mhead [COL];
   int            mcnt  [COL];
   logic          movf, mudf;
   logic [W-1:0]  last_out;
   logic [W-1:0]  exp_q [$];

   psum_col_fifo #(
      .col     (COL),
      .psum_bw (BW),
      .depth   (DEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .in      (din),
      .rd      (rd),
      .out     (dout),
      .out_vld (out_vld),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .err_ovf (err_ovf),
      .err_udf (err_udf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic model_valid();
      logic v = 1'b1;
      for (int k = 0; k < COL; k++) if (mcnt[k] == 0) v = 1'b0;
      return v;
   endfunction

   function automatic logic model_full();
      logic f = 1'b0;
      for (int k = 0; k < COL; k++) if (mcnt[k] == DEPTH) f = 1'b1;
      return f;
   endfunction

   function automatic logic [W-1:0] mkrow(input logic [BW-1:0] base);
      logic [W-1:0] r;
      for (int k = 0; k < COL; k++) r[k*BW +: BW] = base + BW'(k);
      return r;
   endfunction

   // One clock: drive inputs, check pre-edge flags, advance model, check post-edge outputs.
   task automatic cycle(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
      logic           v, f, acc;
      logic [COL-1:0] fpre;
      logic [W-1:0]   row;
      wr  = w;
      din = d;
      rd  = r;
      v   = model_valid();
      f   = model_full();
      check_eq("o_valid", W'(o_valid), W'(v));
      check_eq("o_full", W'(o_full), W'(f));
      check_eq("o_ready", W'(o_ready), W'(!f));
      for (int k = 0; k < COL; k++) fpre[k] = (mcnt[k] == DEPTH);
      acc = r && v;
      if (r && !v) mudf = 1'b1;
      row = '0;
      if (acc) begin
         for (int k = 0; k < COL; k++) begin
            row[k*BW +: BW] = mdata[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % DEPTH;
            mcnt[k]--;
         end
         exp_q.push_back(row);
      end
      for (int k = 0; k < COL; k++) begin
         if (w[k]) begin
            if (fpre[k]) movf = 1'b1;
            else begin
               mdata[k][(mhead[k] + mcnt[k]) % DEPTH] = d[k*BW +: BW];
               mcnt[k]++;
            end
         end
      end
      @(posedge clk);
      #1;
      check_eq("out_vld", W'(out_vld), W'(acc));
      if (acc && exp_q.size() > 0) last_out = exp_q.pop_front();
      check_eq(acc ? "out_row" : "out_hold", dout, last_out);
      check_eq("err_ovf", W'(err_ovf), W'(movf));
      check_eq("err_udf", W'(err_udf), W'(mudf));
      @(negedge clk);
      wr = '0;
      rd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      wr    = '0;
      rd    = 1'b0;
      reset = 1'b1;
      #1;
      check_eq("rst_out", dout, '0);
      check_eq("rst_out_vld", W'(out_vld), '0);
      check_eq("rst_o_valid", W'(o_valid), '0);
      check_eq("rst_o_full", W'(o_full), '0);
      check_eq("rst_o_ready", W'(o_ready), W'(1));
      check_eq("rst_err_ovf", W'(err_ovf), '0);
      check_eq("rst_err_udf", W'(err_udf), '0);
      for (int k = 0; k < COL; k++) begin
         mhead[k] = 0;
         mcnt[k]  = 0;
      end
      movf     = 1'b0;
      mudf     = 1'b0;
      last_out = '0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Idle after reset, then a read with nothing available.
      do_reset();
      cycle('0, '0, 1'b0);
      cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      // Skewed fill: one column per cycle.
      do_reset();
      for (int k = 0; k < COL; k++) cycle(COL'(1) << k, mkrow(16'h0100), 1'b0);
      cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      // Fill every column, overflow column 3, drain in order.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle('1, {COL{BW'(i)}}, 1'b0);
      cycle(8'h08, mkrow(16'hDEAD), 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      // Steady write+read stream across pointer wrap.
      do_reset();
      cycle('1, mkrow(16'hFFF0), 1'b0);
      for (int i = 1; i <= 40; i++) cycle('1, mkrow(16'hFFF0 + BW'(i)), 1'b1);
      cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      // Column 5 full: write and accepted read on the same edge.
      do_reset();
      cycle('1, mkrow(16'h0500), 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) cycle(8'h20, mkrow(16'h0510 + BW'(i)), 1'b0);
      cycle(8'h20, mkrow(16'hBAD0), 1'b1);
      for (int i = 0; i < DEPTH - 1; i++) cycle(8'hDF, mkrow(16'h0600 + BW'(i)), 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      // Asynchronous reset with 10 rows queued, then first row after release.
      do_reset();
      for (int i = 0; i < 10; i++) cycle('1, mkrow(16'h0700 + BW'(i << 4)), 1'b0);
      cycle('0, '0, 1'b1);
      do_reset();
      cycle('1, mkrow(16'h0A00), 1'b0);
      cycle('1, mkrow(16'h0B00), 1'b0);
      cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b1);
      cycle('0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
